// File: rtl/renderer_pkg.sv
// Shared types and timing defaults for the block renderer datapath.
// Build option: SCHED_STATE_GATE_EN (used by block_line_scheduler).
package renderer_pkg;

    typedef struct packed {
        logic        visible;
        logic [11:0] x;
        logic [11:0] y;
        logic [13:0] z;
        logic        color;
        logic [2:0]  direction;
        logic [9:0]  size;
    } block_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic [1:0] PLAYING = 2'd1;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_TOTAL_DEF  = 1650;
    localparam int V_TOTAL_DEF  = 750;

endpackage

// File: rtl/block_row_hit.sv
// Combinational row hit test: does a table entry cover scanline y_next?
// Both edges inclusive; sums are widened so y + size cannot wrap.
module block_row_hit
    import renderer_pkg::*;
(
    input  block_entry_t entry,
    input  logic [9:0]   y_next,
    output logic         hit
);

    logic [12:0] yn;
    logic [12:0] y_lo;
    logic [12:0] y_hi;

    assign yn   = {3'b000, y_next};
    assign y_lo = {1'b0, entry.y};
    assign y_hi = {1'b0, entry.y} + {3'b000, entry.size};
    assign hit  = entry.visible && (yn >= y_lo) && (yn <= y_hi);

endmodule

// File: rtl/block_line_scheduler.sv
// Scans the block table in h-blank and commits the nearest block for the next line.
// Build option: SCHED_STATE_GATE_EN blanks commits unless state is PLAYING.
module block_line_scheduler
    import renderer_pkg::*;
#(
    parameter int N_BLOCKS     = 64,
    parameter int READ_LATENCY = 2,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [10:0]                 x_in,
    input  logic [9:0]                  y_in,
    input  logic [1:0]                  state,
    output logic [$clog2(N_BLOCKS)-1:0] mem_addr_out,
    output logic                        mem_rd_out,
    input  logic [52:0]                 mem_data_in,
    output logic                        block_visible,
    output logic [7:0]                  curr_block_index_out,
    output logic [11:0]                 block_x,
    output logic [11:0]                 block_y,
    output logic [13:0]                 block_z,
    output logic                        block_color,
    output logic [2:0]                  block_direction,
    output logic [9:0]                  block_size,
    output logic                        scan_overrun
);

    localparam int          AW        = $clog2(N_BLOCKS);
    localparam logic [10:0] X_START   = 11'(H_ACTIVE);
    localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N_BLOCKS - 1);

    sched_state_t fsm_state;
    sched_state_t fsm_next;

    logic scan_start;
    logic commit;
    logic abort;

    logic [9:0]              y_next;
    logic [READ_LATENCY-1:0] tag_sr;
    logic                    tag_valid;
    logic [AW-1:0]           ret_idx;
    logic                    last_ret;

    block_entry_t  entry;
    block_entry_t  best;
    logic [AW-1:0] best_idx;
    logic          hit;
    logic          better;
    logic          gate_ok;
    logic          keep;

    assign entry     = mem_data_in;
    assign tag_valid = tag_sr[READ_LATENCY-1];

    // Held candidate is always a visible hit, so its visible bit doubles as "held".
    assign better = tag_valid && hit && (!best.visible || (entry.z < best.z));

`ifdef SCHED_STATE_GATE_EN
    assign gate_ok = (state == PLAYING);
`else
    logic unused_state;
    assign unused_state = ^state;
    assign gate_ok      = 1'b1;
`endif

    assign keep = best.visible && gate_ok;

    block_row_hit u_row_hit (
        .entry  (entry),
        .y_next (y_next),
        .hit    (hit)
    );

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) fsm_state <= IDLE;
        else         fsm_state <= fsm_next;
    end

    // FSM next-state logic
    always_comb begin
        fsm_next = fsm_state;
        unique case (fsm_state)
            IDLE: if (x_in == X_START) fsm_next = SCAN;
            SCAN: begin
                if (x_in == X_LAST) fsm_next = IDLE;
                else if (last_ret)  fsm_next = DONE;
            end
            DONE: if (x_in == X_LAST) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        scan_start = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        unique case (fsm_state)
            IDLE:    scan_start = (x_in == X_START);
            SCAN:    abort      = (x_in == X_LAST);
            DONE:    commit     = (x_in == X_LAST);
            default: ;
        endcase
    end

    // Address issue, return tagging and next-line y capture
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_addr_out <= '0;
            mem_rd_out   <= 1'b0;
            tag_sr       <= '0;
            ret_idx      <= '0;
            last_ret     <= 1'b0;
            y_next       <= '0;
        end else if (scan_start) begin
            mem_addr_out <= '0;
            mem_rd_out   <= 1'b1;
            tag_sr       <= '0;
            ret_idx      <= '0;
            last_ret     <= 1'b0;
            y_next       <= (y_in == Y_LAST) ? 10'd0 : y_in + 10'd1;
        end else if (abort) begin
            mem_addr_out <= '0;
            mem_rd_out   <= 1'b0;
            tag_sr       <= '0;
            last_ret     <= 1'b0;
        end else begin
            if (mem_rd_out) begin
                if (mem_addr_out == ADDR_LAST) begin
                    mem_rd_out   <= 1'b0;
                    mem_addr_out <= '0;
                end else begin
                    mem_addr_out <= mem_addr_out + 1'b1;
                end
            end
            tag_sr[0] <= mem_rd_out;
            for (int i = 1; i < READ_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
            if (tag_valid) ret_idx <= ret_idx + 1'b1;
            if (tag_valid && (ret_idx == ADDR_LAST)) last_ret <= 1'b1;
        end
    end

    // Best-candidate tracking; strict z compare keeps the lower index on ties
    always_ff @(posedge clk_in) begin
        if (!rst_in || scan_start) begin
            best     <= '0;
            best_idx <= '0;
        end else if ((fsm_state == SCAN) && better) begin
            best     <= entry;
            best_idx <= ret_idx;
        end
    end

    // Committed outputs, stable for the whole line between commits
    always_ff @(posedge clk_in) begin
        if (!rst_in || abort) begin
            block_visible        <= 1'b0;
            curr_block_index_out <= '0;
            block_x              <= '0;
            block_y              <= '0;
            block_z              <= '0;
            block_color          <= 1'b0;
            block_direction      <= '0;
            block_size           <= '0;
            scan_overrun         <= rst_in && abort;
        end else if (commit) begin
            block_visible        <= keep;
            curr_block_index_out <= keep ? 8'(best_idx) : 8'd0;
            block_x              <= keep ? best.x : 12'd0;
            block_y              <= keep ? best.y : 12'd0;
            block_z              <= keep ? best.z : 14'd0;
            block_color          <= keep ? best.color : 1'b0;
            block_direction      <= keep ? best.direction : 3'd0;
            block_size           <= keep ? best.size : 10'd0;
            scan_overrun         <= 1'b0;
        end else begin
            scan_overrun <= 1'b0;
        end
    end

endmodule

// File: doc/block_line_scheduler.md
Name: block_line_scheduler

Overview:
- Per-scanline scheduler for the single-block renderer datapath.
- During each horizontal blanking interval it scans the block table (synchronous BRAM, one read per cycle) and finds the nearest visible block covering the next scanline.
- Commits that block's attributes to registered outputs that drive the renderer's block_* inputs for the whole next line.

Parameters:
- N_BLOCKS, 64, table depth; power of two.
- READ_LATENCY, 2, BRAM address-to-data latency in cycles (1..4).
- H_ACTIVE, 1280, first blanking x; a scan starts when x_in == H_ACTIVE.
- H_TOTAL, 1650, pixels per line; commit happens at x_in == H_TOTAL-1.
- V_TOTAL, 750, lines per frame; next-line y wraps V_TOTAL-1 -> 0.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-low reset (0 = reset).
- x_in  input  11  current pixel x.
- y_in  input  10  current pixel y.
- state  input  2  game state.
- mem_addr_out  output  $clog2(N_BLOCKS)  table read address.
- mem_rd_out  output  1  read strobe.
- mem_data_in  input  53  {visible[52], x[51:40], y[39:28], z[27:14], color[13], direction[12:10], size[9:0]}.
- block_visible  output  1  committed block valid.
- curr_block_index_out  output  8  committed table index (zero-extended).
- block_x  output  12, block_y  output  12, block_z  output  14, block_color  output  1, block_direction  output  3, block_size  output  10: committed attributes.
- scan_overrun  output  1  one-cycle pulse when the commit arrives before the scan finishes.

Behaviour:
- Reset (rst_in==0 at posedge): FSM=IDLE; all outputs 0; best-candidate registers cleared. Reset mid-scan abandons the scan with no commit.
- y_next = (y_in == V_TOTAL-1) ? 0 : y_in+1, latched at scan start.
- FSM IDLE -> SCAN when x_in == H_ACTIVE.
- SCAN: issue addresses 0..N_BLOCKS-1 on consecutive cycles with mem_rd_out=1. A READ_LATENCY-deep valid shift register tags returning data. SCAN -> DONE one cycle after the last tagged return.
- Hit test, unsigned, 13-bit extended: visible && y_next >= y && y_next <= y + size. Equality at both edges counts as a hit.
- Selection: a hit replaces the best candidate if no candidate is held or z < best_z (unsigned). On equal z the lower index wins.
- DONE: wait until x_in == H_TOTAL-1, then commit:
  - block_visible = candidate held; attributes = candidate, or 0 if none.
  - Outputs take the new values at the next edge, so they are valid from x=0.
  - Return to IDLE.
- Overrun: if x_in == H_TOTAL-1 while still in SCAN:
  - commit block_visible=0, all attributes 0;
  - pulse scan_overrun for 1 cycle;
  - abort to IDLE.
- Outputs are held constant for the whole line between commits.
- x_in == H_ACTIVE while not IDLE is ignored.
- Latency: scan takes N_BLOCKS + READ_LATENCY + 1 cycles.

Optional Feature:
- Macro SCHED_STATE_GATE_EN.
- Defined: a commit while state != 2'd1 (PLAYING) forces block_visible=0 and all attributes 0. The scan still runs and mem accesses are unchanged.
- Undefined: state is ignored.

Decomposition:
- renderer_pkg holds:
  - block_entry_t packed struct matching the mem_data_in layout;
  - state encodings (PLAYING=2'd1);
  - default timing constants H_ACTIVE/H_TOTAL/V_TOTAL.
- Sub-module block_row_hit: combinational hit test (entry, y_next) -> hit. Reused later by the column scheduler.

Test Plan:
- Table all invisible; y_in=99 line -> at x=0 of line 100, block_visible=0, attributes 0, no overrun.
- Entry 5 {y=90, size=10, z=800}, entry 9 {y=95, size=20, z=300} -> line 100 commits index 9, z=300. Line 110 commits only 9. Line 115 commits 9 (edge inclusive). Line 116 commits none.
- Entries 3 and 7, both covering line 50 with z=400 -> index 3 committed (tie rule).
- y_in=749 scan -> y_next=0. Entry {y=0, size=5} is committed for line 0.
- Sim override H_TOTAL=H_ACTIVE+40 with N_BLOCKS=64 -> scan_overrun pulses once, block_visible=0, FSM back in IDLE before the next H_ACTIVE.
- rst_in=0 asserted mid-SCAN -> next cycle all outputs 0, FSM IDLE. After release, the next line schedules correctly.
- With SCHED_STATE_GATE_EN and state=2'd0, the valid hit from the second scenario commits block_visible=0 while mem_rd_out still toggles for 64 cycles.
